// File: rtl/proc_fetch_pkg.sv
// Shared TinyRV1 fetch definitions: NOP encoding, PC select codes, default reset PC
// and the {pc, inst} entry carried through the fetch buffer.
package proc_fetch_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0200;

    typedef enum logic [1:0] {
        PC_SEL_PC4 = 2'd0,
        PC_SEL_JAL = 2'd1,
        PC_SEL_JR  = 2'd2,
        PC_SEL_BR  = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/proc_fetch_queue.sv
// Small synchronous FIFO with flush; used as the fetch PC tag queue and the instruction buffer.
module proc_fetch_queue #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/proc_fetch.sv
// TinyRV1 stage-F fetch unit: owns pc_F, issues imem requests under a credit limit,
// buffers {pc, inst} for stage D and drops stale responses after a redirect.
// Optional macro PROC_FETCH_BYPASS_EN forwards a response straight to D when the buffer is empty.
module proc_fetch
    import proc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c2d_reg_en_F,
    input  logic [1:0]  c2d_pc_sel_F,
    input  logic        c2d_reg_en_D,
    input  logic [31:0] jal_targ_D,
    input  logic [31:0] jr_targ_D,
    input  logic [31:0] br_targ_X,
    output logic        imemreq_val,
    input  logic        imemreq_rdy,
    output logic [31:0] imemreq_addr,
    input  logic        imemresp_val,
    input  logic [31:0] imemresp_data,
    output logic        inst_val_D,
    output logic [31:0] inst_D,
    output logic [31:0] pc_D
);
    localparam int unsigned CW = $clog2(IBUF_DEPTH + 1);
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic [31:0]   pc_F;
    logic [31:0]   redirect_pc;
    logic [31:0]   tag_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] drop;
    logic          redirect;
    logic          req_fire;
    logic          resp_keep;
    logic          byp_val;
    logic          head_val;
    logic          buf_push;
    logic          buf_pop;
    logic          buf_empty;
    logic          buf_full;
    logic          tag_empty;
    logic          tag_full;
    fetch_entry_t  buf_head;
    fetch_entry_t  resp_entry;

    assign redirect = (c2d_pc_sel_F != PC_SEL_PC4);

    always_comb begin
        redirect_pc = pc_F;
        case (c2d_pc_sel_F)
            PC_SEL_JAL: redirect_pc = jal_targ_D;
            PC_SEL_JR:  redirect_pc = jr_targ_D;
            PC_SEL_BR:  redirect_pc = br_targ_X;
            default:    redirect_pc = pc_F;
        endcase
    end

    // Credit rule: in-flight requests plus buffered entries never exceed the buffer depth.
    assign imemreq_val  = ~rst & c2d_reg_en_F & ~redirect
                        & ((outstanding + buf_count) < CW'(IBUF_DEPTH));
    assign imemreq_addr = pc_F;
    assign req_fire     = imemreq_val & imemreq_rdy;

    assign resp_keep       = imemresp_val & ~redirect & (drop == '0);
    assign resp_entry.pc   = tag_pc;
    assign resp_entry.inst = imemresp_data;

`ifdef PROC_FETCH_BYPASS_EN
    assign byp_val = resp_keep & buf_empty;
`else
    assign byp_val = 1'b0;
`endif

    assign head_val   = ~redirect & ~buf_empty;
    assign inst_val_D = ~rst & (head_val | byp_val);
    assign buf_pop    = head_val & c2d_reg_en_D;
    assign buf_push   = resp_keep & ~(byp_val & c2d_reg_en_D);

    always_comb begin
        inst_D = NOP;
        pc_D   = 32'h0;
        if (!rst && head_val) begin
            inst_D = buf_head.inst;
            pc_D   = buf_head.pc;
        end else if (!rst && byp_val) begin
            inst_D = resp_entry.inst;
            pc_D   = resp_entry.pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_F <= RESET_PC;
        end else if (redirect) begin
            pc_F <= redirect_pc;
        end else if (req_fire) begin
            pc_F <= pc_F + 32'd4;
        end
    end

    // Responses still in flight at a redirect belong to the old path and are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop <= '0;
        end else if (redirect) begin
            drop <= outstanding - CW'(imemresp_val);
        end else if (imemresp_val && (drop != '0)) begin
            drop <= drop - CW'(1);
        end
    end

    // Tag queue occupancy doubles as the outstanding-request count.
    proc_fetch_queue #(.W(32), .DEPTH(IBUF_DEPTH)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (pc_F),
        .pop       (imemresp_val),
        .flush     (1'b0),
        .head      (tag_pc),
        .count     (outstanding),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    proc_fetch_queue #(.W(EW), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (resp_entry),
        .pop       (buf_pop),
        .flush     (redirect),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imemresp_val && tag_empty));
            assert (!(req_fire && tag_full));
            assert (!(buf_push && buf_full && !buf_pop));
        end
    end

endmodule

// File: tb/tb_proc_fetch.sv
// Randomised scoreboard bench for proc_fetch: a latency-randomising memory model and a
// program-order stream model predict every request address and every instruction seen by D.
module tb_proc_fetch;
    import proc_fetch_pkg::*;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0200;
`ifdef PROC_FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        c2d_reg_en_F;
    logic [1:0]  c2d_pc_sel_F;
    logic        c2d_reg_en_D;
    logic [31:0] jal_targ_D;
    logic [31:0] jr_targ_D;
    logic [31:0] br_targ_X;
    logic        imemreq_val;
    logic        imemreq_rdy;
    logic [31:0] imemreq_addr;
    logic        imemresp_val;
    logic [31:0] imemresp_data;
    logic        inst_val_D;
    logic [31:0] inst_D;
    logic [31:0] pc_D;

    proc_fetch #(.RESET_PC(RST_PC), .IBUF_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .c2d_reg_en_F  (c2d_reg_en_F),
        .c2d_pc_sel_F  (c2d_pc_sel_F),
        .c2d_reg_en_D  (c2d_reg_en_D),
        .jal_targ_D    (jal_targ_D),
        .jr_targ_D     (jr_targ_D),
        .br_targ_X     (br_targ_X),
        .imemreq_val   (imemreq_val),
        .imemreq_rdy   (imemreq_rdy),
        .imemreq_addr  (imemreq_addr),
        .imemresp_val  (imemresp_val),
        .imemresp_data (imemresp_data),
        .inst_val_D    (inst_val_D),
        .inst_D        (inst_D),
        .pc_D          (pc_D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_req_addr;
    logic [31:0] prev_addr;
    logic        prev_stall;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_due = 0;
    int fires = 0;
    int pops = 0;
    int first_fire = -1;
    int first_val = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0050_0093;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            rst          = 1'b1;
            imemresp_val = 1'b0;
            imemreq_rdy  = 1'b0;
            c2d_pc_sel_F = 2'd0;
            c2d_reg_en_F = 1'b0;
            c2d_reg_en_D = 1'b0;
        end
        pend_q.delete();
        exp_q.delete();
        exp_q.push_back(RST_PC);
        exp_req_addr = RST_PC;
        last_due     = 0;
        prev_stall   = 1'b0;
        first_fire   = -1;
        first_val    = -1;
        fires        = 0;
        pops         = 0;
    endtask

    // One cycle of stimulus plus the memory model; fsel < 0 picks redirects at random.
    task automatic drive_cycle(input int p_rdy, input int p_en_f, input int p_en_d, input int p_redir,
                               input int kmin, input int kmax, input int fsel, input logic [31:0] ftarg);
        int          sel;
        int          due;
        logic [31:0] targ;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            imemresp_val  = 1'b1;
            imemresp_data = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else begin
            imemresp_val  = 1'b0;
            imemresp_data = $urandom;
        end
        imemreq_rdy  = (int'($urandom_range(99)) < p_rdy);
        c2d_reg_en_F = (int'($urandom_range(99)) < p_en_f);
        c2d_reg_en_D = (int'($urandom_range(99)) < p_en_d);
        jal_targ_D   = {20'h0, 10'($urandom), 2'b00};
        jr_targ_D    = {20'h0, 10'($urandom), 2'b00};
        br_targ_X    = {20'h0, 10'($urandom), 2'b00};
        if (fsel >= 0) begin
            sel = fsel;
        end else begin
            sel = (int'($urandom_range(99)) < p_redir) ? int'($urandom_range(3, 1)) : 0;
        end
        if (fsel > 0) begin
            jal_targ_D = ftarg;
            jr_targ_D  = ftarg;
            br_targ_X  = ftarg;
        end
        c2d_pc_sel_F = 2'(sel);
        if (sel != 0) begin
            targ = (sel == 1) ? jal_targ_D : (sel == 2) ? jr_targ_D : br_targ_X;
            exp_req_addr = targ;
            exp_q.delete();
            exp_q.push_back(targ);
        end
        #1;
        if (sel != 0) check("req_val_on_redirect", 32'(imemreq_val), 32'd0);
        if (prev_stall && imemreq_val) check("req_addr_hold", imemreq_addr, prev_addr);
        if (imemreq_val && imemreq_rdy) begin
            check("req_addr", imemreq_addr, exp_req_addr);
            exp_req_addr = exp_req_addr + 32'd4;
            due = cyc + int'($urandom_range(kmax, kmin));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_q.push_back('{imemreq_addr, due});
            fires++;
            if (first_fire < 0) first_fire = cyc;
        end
        check("outstanding_bound", 32'(pend_q.size() <= int'(DEPTH)), 32'd1);
        prev_stall = imemreq_val & ~imemreq_rdy;
        prev_addr  = imemreq_addr;
    endtask

    task automatic run(input int n, input int p_rdy, input int p_en_f, input int p_en_d,
                       input int p_redir, input int kmin, input int kmax);
        for (int i = 0; i < n; i++) drive_cycle(p_rdy, p_en_f, p_en_d, p_redir, kmin, kmax, -1, 32'h0);
    endtask

    // Monitor: compares every instruction D accepts against the program-order stream.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                check("rst_req_val", 32'(imemreq_val), 32'd0);
                check("rst_inst_val", 32'(inst_val_D), 32'd0);
                check("rst_inst_nop", inst_D, NOP);
                check("rst_pc_zero", pc_D, 32'h0);
            end else if (!inst_val_D) begin
                check("idle_nop", inst_D, NOP);
            end else begin
                if (first_val < 0) first_val = cyc;
                if (c2d_reg_en_D) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty: got pc %h expected none", pc_D);
                    end else begin
                        e = exp_q.pop_front();
                        check("pc_D", pc_D, e);
                        check("inst_D", inst_D, mem_word(e));
                        exp_q.push_back(e + 32'd4);
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        c2d_reg_en_F = 1'b0;
        c2d_pc_sel_F = 2'd0;
        c2d_reg_en_D = 1'b0;
        jal_targ_D   = 32'h0;
        jr_targ_D    = 32'h0;
        br_targ_X    = 32'h0;
        imemreq_rdy  = 1'b0;
        imemresp_val = 1'b0;
        imemresp_data = 32'h0;

        // Free run, 1-cycle memory: fetch-to-D latency.
        do_reset(3);
        run(10, 100, 100, 100, 0, 1, 1);
        check("first_fetch_latency", 32'(first_val - first_fire), 32'(LAT));

        // D back-pressure: only DEPTH requests may issue, then resume in order.
        do_reset(2);
        run(12, 100, 100, 0, 0, 1, 1);
        check("bp_fire_count", 32'(fires), 32'(DEPTH));
        check("bp_no_pops", 32'(pops), 32'd0);
        run(20, 100, 100, 100, 0, 1, 1);
        check("bp_resume_progress", 32'(pops >= 5), 32'd1);

        // jal redirect with two requests in flight.
        do_reset(2);
        for (int i = 0; i < 2; i++) drive_cycle(100, 100, 100, 0, 3, 3, 0, 32'h0);
        drive_cycle(100, 100, 100, 0, 1, 1, 1, 32'h0000_0300);
        for (int i = 0; i < 12; i++) drive_cycle(100, 100, 100, 0, 1, 1, 0, 32'h0);
        check("jal_progress", 32'(pops >= 3), 32'd1);

        // Branch redirect in the same cycle a response lands.
        do_reset(2);
        for (int i = 0; i < 2; i++) drive_cycle(100, 100, 100, 0, 2, 2, 0, 32'h0);
        drive_cycle(100, 100, 100, 0, 1, 1, 3, 32'h0000_0480);
        for (int i = 0; i < 12; i++) drive_cycle(100, 100, 100, 0, 1, 1, 0, 32'h0);
        check("br_progress", 32'(pops >= 3), 32'd1);

        // Memory not ready for three cycles: address must hold.
        do_reset(2);
        drive_cycle(100, 100, 100, 0, 1, 1, 0, 32'h0);
        for (int i = 0; i < 3; i++) drive_cycle(0, 100, 100, 0, 1, 1, 0, 32'h0);
        for (int i = 0; i < 6; i++) drive_cycle(100, 100, 100, 0, 1, 1, 0, 32'h0);

        // Randomised traffic with a reset in the middle.
        run(800, 70, 85, 75, 5, 1, 4);
        run(400, 40, 60, 40, 10, 1, 6);
        do_reset(2);
        run(800, 90, 95, 90, 3, 1, 3);

        // Quiet drain: the stream must keep flowing.
        pops = 0;
        run(40, 100, 100, 100, 0, 1, 2);
        check("drain_progress", 32'(pops >= 10), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
